mem_initiator: RTL and testbench
================================

# mem_initiator

Bus initiator for the shared 8-bit tri-state memory bus with 12-bit address. It accepts single or burst read/write requests from the core over a valid/ready handshake. It drives `addressBus`, `write` and `dataBus` (write data only), and returns read data as a strobed stream. It matches the memory's one-clock registered read latency and its write-on-edge commit.

## Interface
- `ADDR_W`, 12, address width; the address space is 2^ADDR_W bytes and addresses wrap modulo that size.
- `DATA_W`, 8, data width.
- `LEN_W`, 4, burst-length field width; a burst is `reqLen`+1 beats (1..16).

Ports:
- `clock`  in  1  single clock; all state changes on the rising edge.
- `resetN`  in  1  synchronous, active-low reset.
- `reqValid`  in  1  request present.
- `reqReady`  out  1  request accepted on an edge where `reqValid`&`reqReady`.
- `reqWrite`  in  1  1 = write burst, 0 = read burst.
- `reqAddr`  in  ADDR_W  start address.
- `reqLen`  in  LEN_W  beats minus one.
- `wdValid`  in  1  write beat data present.
- `wdReady`  out  1  write beat taken on `wdValid`&`wdReady`.
- `wdData`  in  DATA_W  write beat data.
- `rdValid`  out  1  one-cycle strobe; `rdData` holds a read beat. There is no backpressure.
- `rdData`  out  DATA_W  read beat.
- `done`  out  1  one-cycle pulse at burst completion.
- `addressBus`  out  ADDR_W  memory address, registered.
- `write`  out  1  memory write enable, registered.
- `dataBus`  inout  DATA_W  driven with the write register when `write`=1; high-Z otherwise.

## Operation
- States: IDLE, READ, DRAIN, WRITE.
- `reqReady` = state==IDLE. It is 0 during any cycle whose preceding edge saw `resetN`=0.
- **IDLE, accepting a request:**
  - latch the burst count and the address counter;
  - set `addressBus`<=`reqAddr`;
  - go to READ or WRITE; `write` stays 0.
- **READ:**
  - Each edge: `addressBus`<=`addressBus`+1 (mod 2^ADDR_W) while beats remain to issue.
  - A pending flag marks that the previous edge issued an address. When the flag is set, capture `dataBus` into `rdData` and pulse `rdValid`.
  - After the last address is issued, go to DRAIN.
- **DRAIN:**
  - One edge: capture the final beat, `rdValid`=1, `done`=1, go to IDLE.
- **WRITE:**
  - `wdReady`=1 while beats remain.
  - On a beat handshake: `write`<=1, `addressBus`<=current address, the data register <= `wdData`, advance the address.
  - On an edge with no handshake: `write`<=0 (bus idle; the memory performs a harmless read).
  - On the edge after the last beat handshake: `write`<=0, `done`<=1, go to IDLE.
- Bus contention rule: `dataBus` is driven only while `write`=1. The memory drives it only while `write`=0; both decisions key off the same registered `write`.
- **Reset (`resetN`=0 at an edge), including mid-burst:**
  - state IDLE, `write`=0, `addressBus`=0, `rdValid`=0, `rdData`=0, `done`=0, `dataBus` high-Z;
  - pending beats are discarded and no `done` is issued.

## Timing
- **Read latency:**
  - Request accepted at edge E0 → first `rdValid` in the cycle after E2.
  - Beats then arrive one per cycle, with no bubbles.
  - The last beat comes with `done` in the cycle after E(N+1), where N = beat count.
- **Write:**
  - A beat taken at edge Ek is committed by the memory at E(k+1).
  - `done` is high in the cycle after the commit edge.
  - The minimum is N+1 edges after acceptance when `wdValid` is held high.
- **Done cycle:** state is IDLE, so `reqReady`=1 in the same cycle as `done`. A new request may be accepted at that edge (back-to-back bursts).
- **Address wrap:** 0xFFF + 1 = 0x000 within a burst.
- **Inputs:** `reqLen`/`reqAddr`/`reqWrite` are ignored except at acceptance. `wdValid` is ignored outside WRITE.

## Test plan
- Reset and single write: reset, then write 0x5A to 0x010 with `reqLen`=0.
  - Required: `write`=1 for exactly one cycle with `addressBus`=0x010, `dataBus`=0x5A; `done` follows on the next cycle.
  - A subsequent single read of 0x010 yields `rdData`=0x5A with `rdValid` two cycles after acceptance.
- Burst read across the wrap: preload 0xFFE..0x001 with 0x11,0x22,0x33,0x44; read `reqAddr`=0xFFE, `reqLen`=3.
  - Required: `rdValid` on 4 consecutive cycles with 0x11,0x22,0x33,0x44; `done` with the last beat.
- Stalled write burst: write 4 beats to 0x100 with `wdValid` toggling 1,0,1,0,1,1.
  - Required: `write` low during stall cycles.
  - Required: memory 0x100..0x103 holds the data in order; exactly one `done`.
- Back-to-back bursts: hold `reqValid` high through `done`.
  - Required: the second request is accepted in the `done` cycle; no idle gap beyond the protocol latency; never `write`=1 while the memory is driving.
- Reset mid-burst: assert `resetN`=0 during beat 2 of a 4-beat write.
  - Required: `write`=0 and `dataBus` high-Z after that edge, beats 3-4 not written, no `done`, `reqReady`=1 after release.

Source files
------------

// File: rtl/mem_initiator.sv
// Single/burst initiator for the shared 8-bit tri-state memory bus (12-bit address).
// Read data returns as an rdValid strobe stream two edges behind each issued address.
module mem_initiator #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 4
) (
  input  logic              clock,
  input  logic              resetN,
  input  logic              reqValid,
  output logic              reqReady,
  input  logic              reqWrite,
  input  logic [ADDR_W-1:0] reqAddr,
  input  logic [LEN_W-1:0]  reqLen,
  input  logic              wdValid,
  output logic              wdReady,
  input  logic [DATA_W-1:0] wdData,
  output logic              rdValid,
  output logic [DATA_W-1:0] rdData,
  output logic              done,
  output logic [ADDR_W-1:0] addressBus,
  output logic              write,
  inout  wire  [DATA_W-1:0] dataBus,
  output logic [1:0]        dbgState
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_WRITE = 2'd3
  } state_t;

  localparam logic [LEN_W:0]  LEFT_ONE = 1;
  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

  state_t              r_state;
  state_t              w_next_state;
  logic                r_live;
  logic [LEN_W:0]      r_left;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_pend;
  logic [ADDR_W-1:0]   r_addr_bus;
  logic                r_write;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_rd_valid;
  logic [DATA_W-1:0]   r_rd_data;
  logic                r_done;
  logic                w_req_ready;
  logic                w_wd_ready;
  logic                w_accept;
  logic                w_wd_fire;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
  // ready never depends on valid, and rdValid has no backpressure.
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_wd_fire    = 1'b0;
    w_req_ready  = (r_state == S_IDLE) && r_live;
    w_wd_ready   = (r_state == S_WRITE) && (r_left != '0);
    case (r_state)
      S_IDLE: begin
        if (reqValid && w_req_ready) begin
          w_accept     = 1'b1;
          w_next_state = reqWrite ? S_WRITE : S_READ;
        end
      end
      S_READ: begin
        if (r_left == '0) w_next_state = S_DRAIN;
      end
      S_DRAIN: begin
        w_next_state = S_IDLE;
      end
      S_WRITE: begin
        w_wd_fire = wdValid && w_wd_ready;
        if (r_left == '0) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetN) r_state <= S_IDLE;
    else         r_state <= w_next_state;
  end

  // For reads r_left counts addresses still to issue; for writes it counts beats still to take.
  always_ff @(posedge clock) begin
    if (!resetN) begin
      r_live     <= 1'b0;
      r_left     <= '0;
      r_addr     <= '0;
      r_pend     <= 1'b0;
      r_addr_bus <= '0;
      r_write    <= 1'b0;
      r_wdata    <= '0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
      r_done     <= 1'b0;
    end else begin
      r_live     <= 1'b1;
      r_rd_valid <= 1'b0;
      r_done     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_addr_bus <= reqAddr;
            r_addr     <= reqAddr;
            r_pend     <= 1'b0;
            r_left     <= reqWrite ? ({1'b0, reqLen} + LEFT_ONE) : {1'b0, reqLen};
          end
        end
        S_READ: begin
          // Memory has registered the previous address by now, so from the second
          // READ edge onward dataBus carries a valid beat.
          r_pend <= 1'b1;
          if (r_pend) begin
            r_rd_valid <= 1'b1;
            r_rd_data  <= dataBus;
          end
          if (r_left != '0) begin
            r_addr_bus <= r_addr_bus + ADDR_ONE;
            r_left     <= r_left - LEFT_ONE;
          end
        end
        S_DRAIN: begin
          r_rd_valid <= 1'b1;
          r_rd_data  <= dataBus;
          r_done     <= 1'b1;
        end
        S_WRITE: begin
          if (w_wd_fire) begin
            r_write    <= 1'b1;
            r_addr_bus <= r_addr;
            r_wdata    <= wdData;
            r_addr     <= r_addr + ADDR_ONE;
            r_left     <= r_left - LEFT_ONE;
          end else begin
            r_write <= 1'b0;
          end
          if (r_left == '0) r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign dataBus    = r_write ? r_wdata : {DATA_W{1'bz}};
  assign reqReady   = w_req_ready;
  assign wdReady    = w_wd_ready;
  assign rdValid    = r_rd_valid;
  assign rdData     = r_rd_data;
  assign done       = r_done;
  assign addressBus = r_addr_bus;
  assign write      = r_write;
  assign dbgState   = r_state;

endmodule

// File: tb/tb_mem_initiator.sv
// Directed bench for mem_initiator with a behavioural 4K x 8 memory on the tri-state bus.
module tb_mem_initiator;

  logic        clock = 1'b0;
  logic        resetN;
  logic        reqValid;
  logic        reqWrite;
  logic [11:0] reqAddr;
  logic [3:0]  reqLen;
  logic        wdValid;
  logic [7:0]  wdData;
  wire         reqReady;
  wire         wdReady;
  wire         rdValid;
  wire  [7:0]  rdData;
  wire         done;
  wire  [11:0] addressBus;
  wire         write;
  wire  [7:0]  data_bus;
  wire  [1:0]  dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  mem_initiator dut (
    .clock      (clock),
    .resetN     (resetN),
    .reqValid   (reqValid),
    .reqReady   (reqReady),
    .reqWrite   (reqWrite),
    .reqAddr    (reqAddr),
    .reqLen     (reqLen),
    .wdValid    (wdValid),
    .wdReady    (wdReady),
    .wdData     (wdData),
    .rdValid    (rdValid),
    .rdData     (rdData),
    .done       (done),
    .addressBus (addressBus),
    .write      (write),
    .dataBus    (data_bus),
    .dbgState   (dbg_state)
  );

  // Memory: commits on the edge that sees write=1, otherwise registers a read.
  logic [7:0] mem [0:4095];
  logic [7:0] mem_q;
  always @(posedge clock) begin
    if (write === 1'b1) mem[addressBus] <= data_bus;
    else                mem_q <= mem[addressBus];
  end
  assign data_bus = (write === 1'b1) ? 8'bz : mem_q;

  // Monitor logs, append-only; each test snapshots their sizes before it starts.
  logic [7:0]  rd_q[$];
  int          rd_cyc_q[$];
  int          wr_cyc_q[$];
  logic [11:0] wr_addr_q[$];
  logic [7:0]  wr_data_q[$];
  int          done_cyc_q[$];
  always @(negedge clock) begin
    if (rdValid === 1'b1) begin
      rd_q.push_back(rdData);
      rd_cyc_q.push_back(cyc);
    end
    if (write === 1'b1) begin
      wr_cyc_q.push_back(cyc);
      wr_addr_q.push_back(addressBus);
      wr_data_q.push_back(data_bus);
    end
    if (done === 1'b1) done_cyc_q.push_back(cyc);
  end

  logic [7:0] exp_q[$];
  logic [7:0] wd_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    resetN   = 1'b0;
    reqValid = 1'b0;
    reqWrite = 1'b0;
    reqAddr  = '0;
    reqLen   = '0;
    wdValid  = 1'b0;
    wdData   = '0;
    tick();
    tick();
    check("rst_req_ready", reqReady, 0);
    check("rst_write", write, 0);
    check("rst_addr", addressBus, 0);
    check("rst_rd_valid", rdValid, 0);
    check("rst_rd_data", rdData, 0);
    check("rst_done", done, 0);
    check("rst_state", dbg_state, 0);
    resetN = 1'b1;
    tick();
    check("rst_release_ready", reqReady, 1);
  endtask

  task automatic issue_req(input logic wr, input logic [11:0] a, input logic [3:0] l,
                           input logic keep, output int acc);
    int t;
    t        = 0;
    reqWrite = wr;
    reqAddr  = a;
    reqLen   = l;
    reqValid = 1'b1;
    while (!reqReady && t < 200) begin
      tick();
      t++;
    end
    check("req_ready_seen", reqReady, 1);
    tick();
    acc = cyc;
    if (!keep) reqValid = 1'b0;
  endtask

  task automatic send_beats(input logic [15:0] pat, input int plen);
    int   i;
    logic fire;
    i = 0;
    while (wd_q.size() > 0 && i < 100) begin
      wdValid = (i < plen) ? pat[i] : 1'b1;
      wdData  = wd_q[0];
      fire    = wdValid && wdReady;
      tick();
      if (fire) void'(wd_q.pop_front());
      i++;
    end
    wdValid = 1'b0;
    check("wd_all_taken", wd_q.size(), 0);
  endtask

  task automatic wait_done(input int lim);
    int t;
    t = 0;
    while (!done && t < lim) begin
      tick();
      t++;
    end
    check("done_seen", done, 1);
    tick();
  endtask

  // Beats must land on consecutive cycles starting two after acceptance, done with the last.
  task automatic check_read(input string tag, input int acc, input int n, input int r0, input int d0);
    check({tag, "_beats"}, rd_q.size() - r0, n);
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_data%0d", tag, i), rd_q[r0 + i], exp_q.pop_front());
      check($sformatf("%s_cyc%0d", tag, i), rd_cyc_q[r0 + i], acc + 2 + i);
    end
    check({tag, "_done_cyc"}, done_cyc_q[d0], acc + n + 1);
  endtask

  initial begin
    int acc, acc2, r0, w0, d0;

    do_reset();

    // Single write then single read of 0x010
    w0 = wr_cyc_q.size(); d0 = done_cyc_q.size();
    wd_q = '{8'h5A};
    issue_req(1'b1, 12'h010, 4'd0, 1'b0, acc);
    send_beats(16'hFFFF, 16);
    wait_done(50);
    check("w1_write_cycles", wr_cyc_q.size() - w0, 1);
    check("w1_addr", wr_addr_q[w0], 12'h010);
    check("w1_data", wr_data_q[w0], 8'h5A);
    check("w1_write_cyc", wr_cyc_q[w0], acc + 1);
    check("w1_done_cyc", done_cyc_q[d0], acc + 2);
    check("w1_mem", mem[12'h010], 8'h5A);

    r0 = rd_q.size(); d0 = done_cyc_q.size();
    exp_q = '{8'h5A};
    issue_req(1'b0, 12'h010, 4'd0, 1'b0, acc);
    wait_done(50);
    check_read("r1", acc, 1, r0, d0);

    // Preload across the wrap, then burst-read it back
    w0 = wr_cyc_q.size(); d0 = done_cyc_q.size();
    wd_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    issue_req(1'b1, 12'hFFE, 4'd3, 1'b0, acc);
    send_beats(16'hFFFF, 16);
    wait_done(50);
    check("wrap_w_done_cyc", done_cyc_q[d0], acc + 5);
    check("wrap_w_addr2", wr_addr_q[w0 + 2], 12'h000);
    check("wrap_mem_ffe", mem[12'hFFE], 8'h11);
    check("wrap_mem_fff", mem[12'hFFF], 8'h22);
    check("wrap_mem_000", mem[12'h000], 8'h33);
    check("wrap_mem_001", mem[12'h001], 8'h44);

    r0 = rd_q.size(); d0 = done_cyc_q.size();
    exp_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    issue_req(1'b0, 12'hFFE, 4'd3, 1'b0, acc);
    wait_done(50);
    check_read("wrap_r", acc, 4, r0, d0);
    check("wrap_r_done_cnt", done_cyc_q.size() - d0, 1);

    // Stalled write burst: wdValid 1,0,1,0,1,1
    w0 = wr_cyc_q.size(); d0 = done_cyc_q.size();
    wd_q = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    issue_req(1'b1, 12'h100, 4'd3, 1'b0, acc);
    send_beats(16'h0035, 6);
    wait_done(50);
    check("stall_write_cycles", wr_cyc_q.size() - w0, 4);
    check("stall_wcyc0", wr_cyc_q[w0], acc + 1);
    check("stall_wcyc1", wr_cyc_q[w0 + 1], acc + 3);
    check("stall_wcyc2", wr_cyc_q[w0 + 2], acc + 5);
    check("stall_wcyc3", wr_cyc_q[w0 + 3], acc + 6);
    check("stall_addr3", wr_addr_q[w0 + 3], 12'h103);
    check("stall_done_cnt", done_cyc_q.size() - d0, 1);
    check("stall_done_cyc", done_cyc_q[d0], acc + 7);
    check("stall_mem100", mem[12'h100], 8'hA1);
    check("stall_mem101", mem[12'h101], 8'hB2);
    check("stall_mem102", mem[12'h102], 8'hC3);
    check("stall_mem103", mem[12'h103], 8'hD4);

    // Back-to-back: 2-beat read then a write accepted in the read's done cycle
    r0 = rd_q.size(); w0 = wr_cyc_q.size(); d0 = done_cyc_q.size();
    exp_q = '{8'hA1, 8'hB2};
    issue_req(1'b0, 12'h100, 4'd1, 1'b1, acc);
    wd_q = '{8'h77};
    issue_req(1'b1, 12'h200, 4'd0, 1'b0, acc2);
    send_beats(16'hFFFF, 16);
    wait_done(50);
    check("b2b_accept_cyc", acc2, acc + 4);
    check_read("b2b_r", acc, 2, r0, d0);
    check("b2b_done_cnt", done_cyc_q.size() - d0, 2);
    check("b2b_first_write_cyc", wr_cyc_q[w0], acc2 + 1);
    check("b2b_w_done_cyc", done_cyc_q[d0 + 1], acc2 + 2);
    check("b2b_mem200", mem[12'h200], 8'h77);

    // Reset during beat 2 of a 4-beat write over a prefilled region
    wd_q = '{8'h5C, 8'h5C, 8'h5C, 8'h5C};
    issue_req(1'b1, 12'h300, 4'd3, 1'b0, acc);
    send_beats(16'hFFFF, 16);
    wait_done(50);
    w0 = wr_cyc_q.size(); d0 = done_cyc_q.size();
    issue_req(1'b1, 12'h300, 4'd3, 1'b0, acc);
    wdValid = 1'b1;
    wdData  = 8'hE1;
    tick();
    wdData  = 8'hE2;
    tick();
    resetN  = 1'b0;
    wdData  = 8'hE3;
    tick();
    check("mrst_write", write, 0);
    check("mrst_addr", addressBus, 0);
    check("mrst_req_ready", reqReady, 0);
    check("mrst_done", done, 0);
    check("mrst_rd_valid", rdValid, 0);
    wdValid = 1'b0;
    resetN  = 1'b1;
    tick();
    check("mrst_release_ready", reqReady, 1);
    repeat (5) tick();
    check("mrst_no_done", done_cyc_q.size() - d0, 0);
    check("mrst_write_cycles", wr_cyc_q.size() - w0, 2);
    check("mrst_mem300", mem[12'h300], 8'hE1);
    check("mrst_mem301", mem[12'h301], 8'hE2);
    check("mrst_mem302", mem[12'h302], 8'h5C);
    check("mrst_mem303", mem[12'h303], 8'h5C);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
